// File: rtl/transmisor_serial_pkg.sv
// Shared constants for the serial transmitter: slot states, default idle byte, slot length.
// Build option TRANSMISOR_PARITY_EN appends an even-parity bit to every slot (9-bit slots).
package transmisor_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } slotState_t;

    localparam logic [7:0] IDLE_BYTE_DEF = 8'hBC;

`ifdef TRANSMISOR_PARITY_EN
    localparam int SLOT_BITS = 9;
`else
    localparam int SLOT_BITS = 8;
`endif

    localparam int CNT_W = $clog2(SLOT_BITS);

    // Shifter image of one slot: the byte MSB first, then the parity bit if enabled.
    function automatic logic [SLOT_BITS-1:0] slotWord(input logic [7:0] b);
`ifdef TRANSMISOR_PARITY_EN
        return {b, ^b};
`else
        return b;
`endif
    endfunction

endpackage

// File: rtl/transmisor_serial_if.sv
// Byte-in / bit-out bundle of the serial transmitter.
interface transmisor_serial_if;
    logic [7:0] dataIn;
    logic       validIn;
    logic       readyOut;
    logic       dataOut;
    logic       activeOut;

    modport master (
        output dataIn, validIn,
        input  readyOut, dataOut, activeOut
    );

    modport slave (
        input  dataIn, validIn,
        output readyOut, dataOut, activeOut
    );
endinterface

// File: rtl/transmisor_serial_contador_slot.sv
// Wrapping bit counter 0..SLOT_BITS-1; boundary flags the last bit of each slot.
module contador_slot
    import transmisor_pkg::*;
(
    input  logic clkTx,
    input  logic rst,
    output logic boundary
);

    logic [CNT_W-1:0] bitCnt;

    assign boundary = (bitCnt == CNT_W'(SLOT_BITS - 1));

    always_ff @(posedge clkTx or posedge rst) begin
        if (rst) begin
            bitCnt <= '0;
        end else if (boundary) begin
            bitCnt <= '0;
        end else begin
            bitCnt <= bitCnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/transmisor_serial.sv
// Slot-based serial transmitter: one holding register feeding an MSB-first shifter.
// Define TRANSMISOR_PARITY_EN to append an even-parity bit to every slot.
module transmisor_serial
    import transmisor_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
    input  logic                clkTx,
    input  logic                rst,
    transmisor_serial_if.slave  bus
);

    slotState_t           stateReg, stateNext;
    logic [SLOT_BITS-1:0] shiftReg, shiftNext;
    logic [7:0]           holdReg, holdNext;
    logic                 holdFullReg, holdFullNext;
    logic                 dataOutReg;
    logic                 activeReg;
    logic                 boundary;
    logic                 accept;

    contador_slot uCounter (
        .clkTx    (clkTx),
        .rst      (rst),
        .boundary (boundary)
    );

    // Acceptance only depends on registered state, so readyOut has no input path.
    assign accept       = bus.validIn && !holdFullReg;
    assign bus.readyOut = !holdFullReg;
    assign bus.dataOut  = dataOutReg;
    assign bus.activeOut = activeReg;

    always_comb begin
        stateNext    = stateReg;
        shiftNext    = {shiftReg[SLOT_BITS-2:0], 1'b0};
        holdNext     = holdReg;
        holdFullNext = holdFullReg;

        if (accept) begin
            holdNext     = bus.dataIn;
            holdFullNext = 1'b1;
        end

        // A byte accepted on the boundary edge itself waits for the following slot.
        if (boundary) begin
            if (holdFullReg) begin
                stateNext    = ST_DATA;
                shiftNext    = slotWord(holdReg);
                holdFullNext = 1'b0;
            end else begin
                stateNext = ST_IDLE;
                shiftNext = slotWord(IDLE_BYTE);
            end
        end
    end

    always_ff @(posedge clkTx or posedge rst) begin
        if (rst) begin
            stateReg <= ST_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // activeOut tracks the slot type one clock late, matching dataOut's lag behind the shifter.
    always_ff @(posedge clkTx or posedge rst) begin
        if (rst) begin
            shiftReg    <= slotWord(IDLE_BYTE);
            holdReg     <= '0;
            holdFullReg <= 1'b0;
            dataOutReg  <= 1'b0;
            activeReg   <= 1'b0;
        end else begin
            shiftReg    <= shiftNext;
            holdReg     <= holdNext;
            holdFullReg <= holdFullNext;
            dataOutReg  <= shiftReg[SLOT_BITS-1];
            activeReg   <= (stateReg == ST_DATA);
        end
    end

endmodule

// File: tb/tb_transmisor_serial.sv
// Self-checking bench for transmisor_serial against a slot-queue reference model.
module tb_transmisor_serial;
    import transmisor_pkg::*;

    localparam int         SB   = SLOT_BITS;
    localparam logic [7:0] IDLE = 8'hBC;

    logic clkTx;
    logic rst;
    transmisor_serial_if bus ();

    transmisor_serial #(.IDLE_BYTE(IDLE)) dut (
        .clkTx (clkTx),
        .rst   (rst),
        .bus   (bus)
    );

    initial clkTx = 1'b0;
    always #5 clkTx = ~clkTx;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of slots on the wire, each {isData, byte}.
    logic [8:0] slotQ[$];
    int         mEdge;
    int         mIdx;
    logic       mPend;
    logic [7:0] mPendByte;
    logic       mAccept;
    logic       mBoundary;
    logic       expBit, expAct, expReady;

    function automatic logic evenPar(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2) == 1;
    endfunction

    function automatic logic slotBit(input logic [8:0] s, input int idx);
        logic [7:0] b;
        b = s[7:0];
        if (idx < 8) return b[7 - idx];
        return evenPar(b);
    endfunction

    task automatic modelReset();
        slotQ.delete();
        slotQ.push_back({1'b0, IDLE});
        mEdge = 0; mIdx = 0; mPend = 1'b0; mPendByte = '0;
        mAccept = 1'b0; mBoundary = 1'b0;
        expBit = 1'b0; expAct = 1'b0; expReady = 1'b1;
    endtask

    // Apply inputs for one clock, advance the model on the edge, return at the next falling edge.
    task automatic drive(input logic v, input logic [7:0] d);
        logic [8:0] front;
        bus.validIn = v;
        bus.dataIn  = d;
        @(posedge clkTx);
        mEdge++;
        mAccept   = v && !mPend;
        mBoundary = (mEdge % SB) == 0;
        if (mBoundary) begin
            if (mPend) begin
                slotQ.push_back({1'b1, mPendByte});
                mPend = 1'b0;
            end else begin
                slotQ.push_back({1'b0, IDLE});
            end
        end
        if (mAccept) begin
            mPend     = 1'b1;
            mPendByte = d;
        end
        front  = slotQ[0];
        expBit = slotBit(front, mIdx);
        expAct = front[8];
        mIdx++;
        if (mIdx == SB) begin
            void'(slotQ.pop_front());
            mIdx = 0;
        end
        expReady = !mPend;
        @(negedge clkTx);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.validIn = 1'b0;
        bus.dataIn  = '0;
        repeat (3) @(negedge clkTx);
        checks++;
        if (bus.dataOut !== 1'b0 || bus.activeOut !== 1'b0 || bus.readyOut !== 1'b1) begin
            errors++;
            $display("FAIL reset_state dataOut=%b activeOut=%b readyOut=%b required 0 0 1",
                     bus.dataOut, bus.activeOut, bus.readyOut);
        end
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_idle();
        logic [7:0] firstSlot;
        firstSlot = '0;
        for (int c = 0; c < 2 * SB; c++) begin
            drive(1'b0, 8'h00);
            if (c < 8) firstSlot = {firstSlot[6:0], bus.dataOut};
            checks++;
            if (bus.dataOut !== expBit || bus.activeOut !== expAct || bus.readyOut !== expReady) begin
                errors++;
                $display("FAIL idle cyc=%0d dataOut=%b/%b activeOut=%b/%b readyOut=%b/%b",
                         c, bus.dataOut, expBit, bus.activeOut, expAct, bus.readyOut, expReady);
            end
        end
        checks++;
        if (firstSlot !== IDLE) begin
            errors++;
            $display("FAIL idle_pattern got=%h required=%h", firstSlot, IDLE);
        end
    endtask

    task automatic test_single();
        logic [7:0] got;
        int         actCnt;
        got = '0; actCnt = 0;
        drive(1'b1, 8'hA5);
        for (int c = 0; c < 3 * SB; c++) begin
            if (c > 0) drive(1'b0, 8'h00);
            if (bus.activeOut === 1'b1) begin
                if (actCnt < 8) got = {got[6:0], bus.dataOut};
                actCnt++;
            end
            checks++;
            if (bus.dataOut !== expBit || bus.activeOut !== expAct || bus.readyOut !== expReady) begin
                errors++;
                $display("FAIL single cyc=%0d dataOut=%b/%b activeOut=%b/%b readyOut=%b/%b",
                         c, bus.dataOut, expBit, bus.activeOut, expAct, bus.readyOut, expReady);
            end
        end
        checks++;
        if (got !== 8'hA5 || actCnt != SB) begin
            errors++;
            $display("FAIL single_slot byte=%h active_cycles=%0d required A5 %0d", got, actCnt, SB);
        end
    endtask

    task automatic test_back_to_back();
        logic bits[$];
        int   n;
        int   runs;
        logic prevAct;
        logic sawBusy;
        logic okBits;
        runs = 0; prevAct = 1'b0; sawBusy = 1'b0; n = 0;
        for (int phase = 0; phase < 3; phase++) begin
            n = 0;
            do begin
                if (phase == 0) drive(1'b1, 8'h00);
                else if (phase == 1) drive(1'b1, 8'hFF);
                else drive(1'b0, 8'h00);
                n++;
                if (phase == 1 && bus.readyOut === 1'b0) sawBusy = 1'b1;
                if (bus.activeOut === 1'b1) bits.push_back(bus.dataOut);
                if (bus.activeOut === 1'b1 && prevAct !== 1'b1) runs++;
                prevAct = bus.activeOut;
                checks++;
                if (bus.dataOut !== expBit || bus.activeOut !== expAct || bus.readyOut !== expReady) begin
                    errors++;
                    $display("FAIL b2b ph=%0d n=%0d dataOut=%b/%b activeOut=%b/%b readyOut=%b/%b",
                             phase, n, bus.dataOut, expBit, bus.activeOut, expAct, bus.readyOut, expReady);
                end
            end while ((phase < 2) ? (!mAccept && n < 4 * SB) : (n < 4 * SB));
            checks++;
            if (phase < 2 && !mAccept) begin
                errors++;
                $display("FAIL b2b_accept_timeout phase=%0d got=not_accepted required=accepted", phase);
            end
        end
        okBits = (bits.size() == 2 * SB);
        if (okBits) begin
            for (int i = 0; i < 8; i++) begin
                if (bits[i] !== 1'b0) okBits = 1'b0;
                if (bits[SB + i] !== 1'b1) okBits = 1'b0;
            end
        end
        checks++;
        if (!okBits || runs != 1 || !sawBusy) begin
            errors++;
            $display("FAIL b2b_slots active_bits=%0d runs=%0d busy_seen=%b required %0d 1 1",
                     bits.size(), runs, sawBusy, 2 * SB);
        end
    endtask

    task automatic test_coincide();
        int         n;
        int         wait1;
        logic [7:0] got;
        int         gotN;
        n = 0;
        while (!(((mEdge + 1) % SB) == 0 && !mPend) && n < 4 * SB) begin
            drive(1'b0, 8'h00);
            n++;
        end
        drive(1'b1, 8'h3C);
        wait1 = 0; got = '0; gotN = 0;
        for (int c = 0; c < 3 * SB; c++) begin
            drive(1'b0, 8'h00);
            if (bus.activeOut === 1'b1) begin
                if (gotN < 8) got = {got[6:0], bus.dataOut};
                gotN++;
            end else if (gotN == 0) begin
                wait1++;
            end
            checks++;
            if (bus.dataOut !== expBit || bus.activeOut !== expAct || bus.readyOut !== expReady) begin
                errors++;
                $display("FAIL coincide cyc=%0d dataOut=%b/%b activeOut=%b/%b readyOut=%b/%b",
                         c, bus.dataOut, expBit, bus.activeOut, expAct, bus.readyOut, expReady);
            end
        end
        checks++;
        if (wait1 != SB || got !== 8'h3C) begin
            errors++;
            $display("FAIL coincide_slot idle_cycles=%0d byte=%h required %0d 3C", wait1, got, SB);
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [7:0] d;
        for (int c = 0; c < 400; c++) begin
            v = ($urandom % 3) != 0;
            d = 8'($urandom);
            drive(v, d);
            checks++;
            if (bus.dataOut !== expBit || bus.activeOut !== expAct || bus.readyOut !== expReady) begin
                errors++;
                $display("FAIL random cyc=%0d v=%b d=%h dataOut=%b/%b activeOut=%b/%b readyOut=%b/%b",
                         c, v, d, bus.dataOut, expBit, bus.activeOut, expAct, bus.readyOut, expReady);
            end
        end
        for (int c = 0; c < 3 * SB; c++) drive(1'b0, 8'h00);
    endtask

`ifdef TRANSMISOR_PARITY_EN
    task automatic test_parity();
        logic idleBits[$];
        logic dataBits[$];
        int   n;
        n = 0;
        while ((mEdge % SB) != 0 && n < 2 * SB) begin
            drive(1'b0, 8'h00);
            n++;
        end
        for (int c = 0; c < SB; c++) begin
            drive(1'b0, 8'h00);
            idleBits.push_back(bus.dataOut);
        end
        checks++;
        if (idleBits[8] !== 1'b1) begin
            errors++;
            $display("FAIL parity_idle got=%b required=1", idleBits[8]);
        end
        n = 0;
        do begin drive(1'b1, 8'hA5); n++; end while (!mAccept && n < 4 * SB);
        n = 0;
        do begin drive(1'b1, 8'h07); n++; end while (!mAccept && n < 4 * SB);
        for (int c = 0; c < 4 * SB; c++) begin
            if (c > 0) drive(1'b0, 8'h00);
            if (bus.activeOut === 1'b1) dataBits.push_back(bus.dataOut);
        end
        checks++;
        if (dataBits.size() != 18 || dataBits[8] !== 1'b0 || dataBits[17] !== 1'b1) begin
            errors++;
            $display("FAIL parity_data bits=%0d requires 18 with par(A5)=0 par(07)=1", dataBits.size());
        end
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        int actCnt;
        int lateAct;
        n = 0;
        do begin drive(1'b1, 8'h5A); n++; end while (!mAccept && n < 4 * SB);
        n = 0;
        do begin drive(1'b1, 8'hC3); n++; end while (!mAccept && n < 4 * SB);
        actCnt = 0; n = 0;
        while (actCnt < 5 && n < 4 * SB) begin
            drive(1'b0, 8'h00);
            if (expAct) actCnt++;
            n++;
        end
        checks++;
        if (actCnt != 5 || bus.activeOut !== 1'b1 || bus.readyOut !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_setup active_cycles=%0d activeOut=%b readyOut=%b required 5 1 0",
                     actCnt, bus.activeOut, bus.readyOut);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.dataOut !== 1'b0 || bus.readyOut !== 1'b1 || bus.activeOut !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async dataOut=%b readyOut=%b activeOut=%b required 0 1 0",
                     bus.dataOut, bus.readyOut, bus.activeOut);
        end
        @(negedge clkTx);
        rst = 1'b0;
        modelReset();
        lateAct = 0;
        for (int c = 0; c < 3 * SB; c++) begin
            drive(1'b0, 8'h00);
            if (bus.activeOut === 1'b1) lateAct++;
            checks++;
            if (bus.dataOut !== expBit || bus.activeOut !== expAct || bus.readyOut !== expReady) begin
                errors++;
                $display("FAIL rstmid_restart cyc=%0d dataOut=%b/%b activeOut=%b/%b readyOut=%b/%b",
                         c, bus.dataOut, expBit, bus.activeOut, expAct, bus.readyOut, expReady);
            end
        end
        checks++;
        if (lateAct != 0) begin
            errors++;
            $display("FAIL rstmid_discard active_cycles=%0d required 0", lateAct);
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_coincide();
        test_random();
`ifdef TRANSMISOR_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
